// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 6-bit condition flag register and condition select.
// Optional same-cycle flag bypass into cond_true: define EX_MEM_FLAG_FWD_EN.
module ex_mem_stage #(
  parameter int         REG_ADDR_W = 5,
  parameter logic [5:0] FLAG_RST   = 6'b000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [32:0]           ex_alu_res,
  input  logic [4:0]            ex_flags,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_flag_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [31:0]           ex_store_data,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [2:0]            cond_sel,
  output logic                  mem_valid,
  output logic [31:0]           mem_alu_out,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [31:0]           mem_store_data,
  output logic [5:0]            flag_reg,
  output logic                  cond_true
);

  logic                  valid_q, valid_d;
  logic [31:0]           alu_q, alu_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_wr_q, reg_wr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [31:0]           sdata_q, sdata_d;
  logic [5:0]            flag_q, flag_d;
  logic                  flag_load;
  logic [5:0]            flag_eff;

  // Flag update needs a live, unsquashed, advancing instruction.
  assign flag_load = ex_valid && ex_flag_write && !stall && !flush;

  always_comb begin
    valid_d  = valid_q;
    alu_d    = alu_q;
    rd_d     = rd_q;
    reg_wr_d = reg_wr_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    sdata_d  = sdata_q;
    flag_d   = flag_q;
    if (flush) begin
      // Squash kills the slot but keeps the data fields as they were.
      valid_d  = 1'b0;
      reg_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
    end else if (!stall) begin
      valid_d  = ex_valid;
      alu_d    = ex_alu_res[31:0];
      rd_d     = ex_rd;
      sdata_d  = ex_store_data;
      reg_wr_d = ex_reg_write & ex_valid;
      mem_rd_d = ex_mem_read  & ex_valid;
      mem_wr_d = ex_mem_write & ex_valid;
    end
    if (flag_load) flag_d = {ex_alu_res[32], ex_flags};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      rd_q     <= '0;
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      sdata_q  <= '0;
      flag_q   <= FLAG_RST;
    end else begin
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      rd_q     <= rd_d;
      reg_wr_q <= reg_wr_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      sdata_q  <= sdata_d;
      flag_q   <= flag_d;
    end
  end

`ifdef EX_MEM_FLAG_FWD_EN
  // Bypass ignores stall: the writer in EX is the newest flag producer.
  assign flag_eff = (ex_valid && ex_flag_write && !flush) ? {ex_alu_res[32], ex_flags} : flag_q;
`else
  assign flag_eff = flag_q;
`endif

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'd0:    cond_true = flag_eff[0];
      3'd1:    cond_true = flag_eff[1];
      3'd2:    cond_true = flag_eff[2];
      3'd3:    cond_true = flag_eff[3];
      3'd4:    cond_true = flag_eff[4];
      3'd5:    cond_true = flag_eff[5];
      3'd6:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign mem_valid      = valid_q;
  assign mem_alu_out    = alu_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_wr_q;
  assign mem_mem_read   = mem_rd_q;
  assign mem_mem_write  = mem_wr_q;
  assign mem_store_data = sdata_q;
  assign flag_reg       = flag_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed table-driven bench for ex_mem_stage plus reset and bypass sequences.
module tb_ex_mem_stage;

  localparam logic [5:0] FRST = 6'b100100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [32:0] ex_alu_res = '0;
  logic [4:0]  ex_flags = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0, ex_flag_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [31:0] ex_store_data = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [2:0]  cond_sel = '0;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, cond_true;
  logic [31:0] mem_alu_out, mem_store_data;
  logic [4:0]  mem_rd;
  logic [5:0]  flag_reg;

  int checks = 0;
  int failures = 0;

  ex_mem_stage #(.REG_ADDR_W(5), .FLAG_RST(FRST)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
    .ex_flags(ex_flags), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_flag_write(ex_flag_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .stall(stall), .flush(flush), .cond_sel(cond_sel),
    .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_store_data(mem_store_data), .flag_reg(flag_reg), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [32:0] alu;
    logic [4:0]  fl;
    logic [4:0]  rd;
    logic        rw, fw, mr, mw;
    logic [31:0] sd;
    logic        st, fu;
    logic [2:0]  cs;
    logic        e_v;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw;
    logic [31:0] e_sd;
    logic [5:0]  e_fl;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cond_of(input logic [5:0] f, input logic [2:0] cs);
    case (cs)
      3'd6:    return 1'b1;
      3'd7:    return 1'b0;
      default: return f[cs];
    endcase
  endfunction

  // Expected cond_true from the expected flag register and the inputs still on EX.
  function automatic logic exp_cond(input logic [5:0] f, input vec_t t);
    logic [5:0] e;
    e = f;
`ifdef EX_MEM_FLAG_FWD_EN
    if (t.v && t.fw && !t.fu) e = {t.alu[32], t.fl};
`endif
    return cond_of(e, t.cs);
  endfunction

  task automatic drive(input vec_t t);
    ex_valid = t.v; ex_alu_res = t.alu; ex_flags = t.fl; ex_rd = t.rd;
    ex_reg_write = t.rw; ex_flag_write = t.fw; ex_mem_read = t.mr; ex_mem_write = t.mw;
    ex_store_data = t.sd; stall = t.st; flush = t.fu; cond_sel = t.cs;
  endtask

  initial begin
    //          v  alu             fl        rd     rw fw mr mw sd            st fu cs  | e_v e_alu         e_rd   rw mr mw e_sd          e_fl
    vecs[0]  = '{1, 33'h1_0000_0000, 5'b10001, 5'd3,  1, 1, 0, 0, 32'hAAAA5555, 0, 0, 3'd5, 1, 32'h00000000, 5'd3,  1, 0, 0, 32'hAAAA5555, 6'b110001};
    vecs[1]  = '{1, 33'h0_1234_5678, 5'b00100, 5'd7,  0, 0, 1, 0, 32'h000000FF, 0, 0, 3'd2, 1, 32'h12345678, 5'd7,  0, 1, 0, 32'h000000FF, 6'b110001};
    vecs[2]  = '{1, 33'h0_0000_0010, 5'b00001, 5'd31, 0, 1, 0, 1, 32'hDEADBEEF, 0, 0, 3'd0, 1, 32'h00000010, 5'd31, 0, 0, 1, 32'hDEADBEEF, 6'b000001};
    vecs[3]  = '{0, 33'h1_FFFF_FFFF, 5'b11111, 5'd5,  1, 1, 1, 1, 32'h11111111, 0, 0, 3'd4, 0, 32'hFFFFFFFF, 5'd5,  0, 0, 0, 32'h11111111, 6'b000001};
    vecs[4]  = '{1, 33'h0_0000_0042, 5'b11111, 5'd9,  1, 1, 1, 1, 32'h00000022, 1, 0, 3'd6, 0, 32'hFFFFFFFF, 5'd5,  0, 0, 0, 32'h11111111, 6'b000001};
    vecs[5]  = '{1, 33'h1_0000_0043, 5'b01010, 5'd10, 1, 1, 0, 1, 32'h00000023, 1, 0, 3'd7, 0, 32'hFFFFFFFF, 5'd5,  0, 0, 0, 32'h11111111, 6'b000001};
    vecs[6]  = '{1, 33'h0_0000_0044, 5'b00000, 5'd11, 1, 1, 1, 0, 32'h00000024, 1, 0, 3'd0, 0, 32'hFFFFFFFF, 5'd5,  0, 0, 0, 32'h11111111, 6'b000001};
    vecs[7]  = '{1, 33'h0_0000_0077, 5'b11110, 5'd2,  1, 1, 0, 0, 32'h00000033, 1, 1, 3'd0, 0, 32'hFFFFFFFF, 5'd5,  0, 0, 0, 32'h11111111, 6'b000001};
    vecs[8]  = '{1, 33'h1_8000_0000, 5'b00100, 5'd4,  1, 1, 0, 0, 32'h00000044, 0, 0, 3'd3, 1, 32'h80000000, 5'd4,  1, 0, 0, 32'h00000044, 6'b100100};
    vecs[9]  = '{1, 33'h0_0000_0099, 5'b01000, 5'd6,  1, 1, 1, 1, 32'h00000055, 0, 1, 3'd1, 0, 32'h80000000, 5'd4,  0, 0, 0, 32'h00000044, 6'b100100};
    vecs[10] = '{1, 33'h0_0000_0000, 5'b00010, 5'd8,  1, 1, 0, 0, 32'h00000066, 0, 0, 3'd1, 1, 32'h00000000, 5'd8,  1, 0, 0, 32'h00000066, 6'b000010};
    vecs[11] = '{0, 33'h0_0000_0005, 5'b00000, 5'd0,  0, 0, 0, 0, 32'h00000000, 0, 0, 3'd1, 0, 32'h00000005, 5'd0,  0, 0, 0, 32'h00000000, 6'b000010};

    #12;
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_flag", {26'd0, flag_reg}, {26'd0, FRST});
    chk("rst_alu", mem_alu_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, mem_valid}, {31'd0, vecs[i].e_v});
      chk($sformatf("v%0d_alu", i), mem_alu_out, vecs[i].e_alu);
      chk($sformatf("v%0d_rd", i), {27'd0, mem_rd}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_ctl", i), {29'd0, mem_reg_write, mem_mem_read, mem_mem_write},
          {29'd0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw});
      chk($sformatf("v%0d_sd", i), mem_store_data, vecs[i].e_sd);
      chk($sformatf("v%0d_flag", i), {26'd0, flag_reg}, {26'd0, vecs[i].e_fl});
      chk($sformatf("v%0d_cond", i), {31'd0, cond_true}, {31'd0, exp_cond(vecs[i].e_fl, vecs[i])});
    end

    // Asynchronous reset asserted between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_alu", mem_alu_out, 32'd0);
    chk("arst_flag", {26'd0, flag_reg}, {26'd0, FRST});
    chk("arst_ctl", {28'd0, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);

    // Leave reset while stalled: held state is the reset state.
    @(negedge clk);
    ex_valid = 1; ex_alu_res = 33'h1_0000_00AB; ex_flags = 5'b11111; ex_rd = 5'd12;
    ex_reg_write = 1; ex_flag_write = 1; ex_mem_read = 1; ex_mem_write = 1;
    ex_store_data = 32'h0BADF00D; stall = 1; flush = 0; cond_sel = 3'd5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstall_valid", {31'd0, mem_valid}, 32'd0);
    chk("rstall_alu", mem_alu_out, 32'd0);
    chk("rstall_flag", {26'd0, flag_reg}, {26'd0, FRST});

    // Flag bypass: flag_reg zero bit is 0, EX writes zero=1.
    @(negedge clk);
    stall = 0; ex_alu_res = 33'h0_0000_0000; ex_flags = 5'b00001; cond_sel = 3'd0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    #1;
`ifdef EX_MEM_FLAG_FWD_EN
    chk("byp_same", {31'd0, cond_true}, 32'd1);
`else
    chk("byp_same", {31'd0, cond_true}, 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("byp_next", {31'd0, cond_true}, 32'd1);
    chk("byp_flag", {26'd0, flag_reg}, 32'd1);
    chk("byp_valid", {31'd0, mem_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
